// File: rtl/xor_mismatch_counter.sv
// rtl/xor_mismatch_counter.sv - framed Hamming-distance accumulator over serial a/b bit pairs
module xor_mismatch_counter #(
  parameter int W      = 8,
  parameter int THRESH = 3,
  parameter int MAXLEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         valid,
  input  logic         a,
  input  logic         b,
  input  logic         last,
  output logic         x,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] count,
  output logic [W-1:0] nbits,
  output logic         err,
  output logic         sat,
  output logic         trunc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] LEN_MAX = W'(MAXLEN);

  state_t       state, state_n;
  logic         x_n, busy_n, done_n, err_n, sat_n, trunc_n;
  logic [W-1:0] count_n, nbits_n, nbits_inc;
  logic         mis;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_n   = state;
    x_n       = x;
    busy_n    = busy;
    done_n    = 1'b0;
    count_n   = count;
    nbits_n   = nbits;
    err_n     = err;
    sat_n     = sat;
    trunc_n   = trunc;
    mis       = a ^ b;
    nbits_inc = nbits + W'(1);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          busy_n  = 1'b1;
          x_n     = 1'b0;
          count_n = '0;
          nbits_n = '0;
          err_n   = 1'b0;
          sat_n   = 1'b0;
          trunc_n = 1'b0;
        end
      end
      RUN: begin
        if (valid) begin
          x_n     = mis;
          nbits_n = nbits_inc;
          if (mis) begin
            if (count == CNT_MAX) sat_n = 1'b1;
            else                  count_n = count + W'(1);
          end
          // Frame closes on last or on the MAXLEN-th bit; err uses the count including this bit.
          if (last || nbits_inc == LEN_MAX) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            trunc_n = !last;
            err_n   = (32'(count_n) >= 32'(THRESH));
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      nbits <= '0;
      err   <= 1'b0;
      sat   <= 1'b0;
      trunc <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      busy  <= busy_n;
      done  <= done_n;
      count <= count_n;
      nbits <= nbits_n;
      err   <= err_n;
      sat   <= sat_n;
      trunc <= trunc_n;
    end
  end

endmodule

// File: tb/tb_xor_mismatch_counter.sv
// tb/tb_xor_mismatch_counter.sv - randomized self-checking bench for xor_mismatch_counter
module tb_xor_mismatch_counter;

  localparam int W      = 8;
  localparam int THRESH = 3;
  localparam int MAXLEN = 16;
  localparam int CMAX   = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, start, valid, a, b, last;
  logic         x, busy, done, err, sat, trunc;
  logic [W-1:0] count, nbits;

  int n_cmp  = 0;
  int n_fail = 0;

  int fa[32];
  int fb[32];
  int fgap[32];

  xor_mismatch_counter #(.W(W), .THRESH(THRESH), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .last(last),
    .x(x), .busy(busy), .done(done), .count(count), .nbits(nbits),
    .err(err), .sat(sat), .trunc(trunc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 32; i++) begin
      fa[i] = 0; fb[i] = 0; fgap[i] = 0;
    end
  endtask

  // Drives one frame from fa/fb/fgap; ends on last_idx or when MAXLEN bits are accepted.
  // The start cycle also carries a valid mismatch (must be ignored), start toggles randomly
  // mid-frame (must be ignored), and start is held high in the DONE cycle (must be ignored).
  task automatic do_frame(input int last_idx);
    int  exp_mis, exp_n, exp_cnt;
    logic exp_x;
    bit  ended;
    start = 1'b1; valid = 1'b1; a = 1'b1; b = 1'b0; last = 1'b1;
    step();
    start = 1'b0; valid = 1'b0; last = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== '0 || nbits !== '0 || x !== 1'b0 ||
        err !== 1'b0 || trunc !== 1'b0 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_start: busy=%b done=%b count=%0d nbits=%0d x=%b err=%b trunc=%b sat=%b, required busy=1 rest 0",
               busy, done, count, nbits, x, err, trunc, sat);
    end
    exp_mis = 0; exp_n = 0; exp_x = 1'b0; ended = 1'b0;
    for (int i = 0; i < 32 && !ended; i++) begin
      for (int g = 0; g < fgap[i]; g++) begin
        valid = 1'b0; a = 1'($urandom); b = 1'($urandom); last = 1'($urandom); start = 1'($urandom);
        step();
        exp_cnt = (exp_mis > CMAX) ? CMAX : exp_mis;
        n_cmp++;
        if (count !== W'(exp_cnt) || nbits !== W'(exp_n) || x !== exp_x || busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_hold: count=%0d nbits=%0d x=%b busy=%b done=%b, required %0d %0d %b 1 0",
                   count, nbits, x, busy, done, exp_cnt, exp_n, exp_x);
        end
      end
      valid = 1'b1; a = 1'(fa[i]); b = 1'(fb[i]); last = (i == last_idx); start = 1'($urandom);
      step();
      exp_n++;
      exp_x = (fa[i] != fb[i]);
      if (exp_x) exp_mis++;
      exp_cnt = (exp_mis > CMAX) ? CMAX : exp_mis;
      n_cmp++;
      if (x !== exp_x || count !== W'(exp_cnt) || nbits !== W'(exp_n)) begin
        n_fail++;
        $display("FAIL bit_accept[%0d]: x=%b count=%0d nbits=%0d, required %b %0d %0d",
                 i, x, count, nbits, exp_x, exp_cnt, exp_n);
      end
      if (i == last_idx || exp_n == MAXLEN) begin
        ended = 1'b1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== (exp_cnt >= THRESH) ||
            trunc !== (i != last_idx) || sat !== (exp_mis > CMAX)) begin
          n_fail++;
          $display("FAIL frame_end: done=%b busy=%b err=%b trunc=%b sat=%b, required 1 0 %b %b %b",
                   done, busy, err, trunc, sat, exp_cnt >= THRESH, i != last_idx, exp_mis > CMAX);
        end
      end else begin
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_frame: done=%b busy=%b, required 0 1", done, busy);
        end
      end
    end
    start = 1'b1; valid = 1'b1; a = 1'b1; b = 1'b0; last = 1'b1;
    step();
    start = 1'b0; valid = 1'b0; last = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== W'(exp_cnt) || nbits !== W'(exp_n)) begin
      n_fail++;
      $display("FAIL after_done: done=%b busy=%b count=%0d nbits=%0d, required 0 0 %0d %0d",
               done, busy, count, nbits, exp_cnt, exp_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; valid = 1'b1; a = 1'b1; b = 1'b0; last = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if ({x, busy, done, count, nbits, err, sat, trunc} !== '0) begin
      n_fail++;
      $display("FAIL reset: x=%b busy=%b done=%b count=%0d nbits=%0d err=%b sat=%b trunc=%b, required all 0",
               x, busy, done, count, nbits, err, sat, trunc);
    end
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    clear_frame();
    fa[0] = 1; fa[1] = 0; fa[2] = 1; fa[3] = 0;
    fb[0] = 0; fb[1] = 1; fb[2] = 1; fb[3] = 0;
    do_frame(3);
  endtask

  task automatic test_gaps();
    clear_frame();
    for (int i = 0; i < 5; i++) begin fa[i] = 1; fb[i] = 0; end
    fgap[1] = 1; fgap[2] = 1;
    do_frame(4);
  endtask

  task automatic test_maxlen(input bit with_last);
    int k, p;
    clear_frame();
    for (int i = 0; i < 16; i++) begin fa[i] = int'($urandom_range(0, 1)); fb[i] = fa[i]; end
    k = 0;
    while (k < 3) begin
      p = int'($urandom_range(0, 15));
      if (fa[p] == fb[p]) begin fb[p] = 1 - fa[p]; k++; end
    end
    do_frame(with_last ? 15 : -1);
  endtask

  task automatic test_idle_hold();
    clear_frame();
    fa[0] = 1; fa[1] = 1;
    do_frame(3);
    for (int i = 0; i < 5; i++) begin
      valid = 1'($urandom); a = 1'($urandom); b = 1'($urandom); last = 1'($urandom);
      step();
      n_cmp++;
      if (count !== W'(2) || nbits !== W'(4) || err !== 1'b0 || trunc !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: count=%0d nbits=%0d err=%b trunc=%b done=%b busy=%b, required 2 4 0 0 0 0",
                 i, count, nbits, err, trunc, done, busy);
      end
    end
    start = 1'b1; valid = 1'b0;
    step();
    start = 1'b0;
    n_cmp++;
    if (count !== '0 || nbits !== '0 || err !== 1'b0 || x !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: count=%0d nbits=%0d err=%b x=%b busy=%b, required 0 0 0 0 1",
               count, nbits, err, x, busy);
    end
    valid = 1'b1; a = 1'b0; b = 1'b0; last = 1'b1;
    step();
    valid = 1'b0; last = 1'b0;
    step();
  endtask

  task automatic test_rst_midframe();
    start = 1'b1;
    step();
    start = 1'b0; valid = 1'b1; a = 1'b1; b = 1'b0; last = 1'b0;
    step();
    step();
    rst = 1'b1; last = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0; last = 1'b0;
    n_cmp++;
    if ({x, busy, done, count, nbits, err, sat, trunc} !== '0) begin
      n_fail++;
      $display("FAIL rst_midframe: x=%b busy=%b done=%b count=%0d nbits=%0d err=%b sat=%b trunc=%b, required all 0",
               x, busy, done, count, nbits, err, sat, trunc);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_done: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_random();
    int li;
    for (int f = 0; f < 25; f++) begin
      clear_frame();
      for (int i = 0; i < 32; i++) begin
        fa[i]   = int'($urandom_range(0, 1));
        fb[i]   = int'($urandom_range(0, 1));
        fgap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      li = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 19));
      do_frame(li);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0; last = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_maxlen(1'b0);
    test_maxlen(1'b1);
    test_idle_hold();
    test_rst_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
